// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add unsigned multiply.
// Optional macro ALU_MULHI_EN enables opcode 9 (MULHU, high half of the product).
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] Source1,
  input  logic [WIDTH-1:0] Source2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is sampled only in IDLE; busy stays high from the latch edge
  // through the DONE cycle, and done pulses for exactly that one DONE cycle.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_MUL = 4'd8, OP_MULHU = 4'd9;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q, ovf_q, busy_q, done_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_ovf_d;
  logic [WIDTH-1:0]   sum_d, diff_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mul_res_d;
  logic               mul_last_d;
  logic               start_mul_d;

  always_comb begin
    start_mul_d = (opcode == OP_MUL);
`ifdef ALU_MULHI_EN
    if (opcode == OP_MULHU) start_mul_d = 1'b1;
`endif
  end

  always_comb begin
    sum_d     = a_q + b_q;
    diff_d    = a_q - b_q;
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res_d = sum_d;
        alu_ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_d;
        alu_ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res_d = a_q & b_q;
      OP_OR:  alu_res_d = a_q | b_q;
      OP_XOR: alu_res_d = a_q ^ b_q;
      OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL: alu_res_d = a_q << b_q[4:0];
      OP_SRL: alu_res_d = a_q >> b_q[4:0];
      default: begin
        alu_res_d = '0;
        alu_ovf_d = 1'b0;
      end
    endcase
  end

  // One multiply step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right, carry included.
  always_comb begin
    mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    acc_d      = {mul_sum_d, acc_q[WIDTH-1:1]};
    mul_last_d = (cnt_q == CNT_W'(WIDTH-1));
    mul_res_d  = acc_d[WIDTH-1:0];
`ifdef ALU_MULHI_EN
    if (op_q == OP_MULHU) mul_res_d = acc_d[2*WIDTH-1:WIDTH];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= Source1;
            b_q     <= Source2;
            op_q    <= opcode;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= start_mul_d ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= alu_res_d;
          zero_q   <= (alu_res_d == '0);
          ovf_q    <= alu_ovf_d;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_MUL: begin
          acc_q <= acc_d;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_last_d) begin
            result_q <= mul_res_d;
            zero_q   <= (mul_res_d == '0);
            ovf_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: latency, results, flags, ignored start, async reset abort.
module tb_alu_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   opcode = '0;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res = '0;

  alu_exec #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .Source1(src1), .Source2(src2), .busy(busy), .done(done),
    .result(result), .zero(zero), .overflow(overflow), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_zero, input logic exp_ovf,
                        input int exp_lat, input int inject_at);
    int lat;
    exp_q.push_back(exp_res);
    src1 = a; src2 = b; opcode = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src1 = $urandom; src2 = $urandom; opcode = 4'($urandom_range(0, 15));
    check({tag, ".hold"}, result, last_res);
    lat = 1;
    while (!done && lat < 100) begin
      if (inject_at != 0 && lat == inject_at) begin
        start = 1'b1; opcode = 4'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, ".lat"}, W'(lat), W'(exp_lat));
    check({tag, ".busy"}, W'(busy), W'(1));
    check({tag, ".res"}, result, exp_q.pop_front());
    check({tag, ".zero"}, W'(zero), W'(exp_zero));
    check({tag, ".ovf"}, W'(overflow), W'(exp_ovf));
    last_res = exp_res;
    @(posedge clk); #1;
    check({tag, ".idle"}, W'({busy, done}), W'(0));
  endtask

  initial begin : stim
    int seen;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", W'(busy), W'(0));
    check("rst.done", W'(done), W'(0));
    check("rst.res", result, '0);
    check("rst.flags", W'({zero, overflow}), W'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 2, 0);
    run_op("sub_eq",  4'd1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 2, 0);
    run_op("slt",     4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 2, 0);
    run_op("srl",     4'd7, 32'h8000_0001, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0, 2, 0);
    run_op("sll",     4'd6, 32'h8000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0, 2, 0);
    run_op("and",     4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 2, 0);
    run_op("or",      4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0, 2, 0);
    run_op("xor",     4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1'b0, 2, 0);
    run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 2, 0);
    run_op("sll0",    4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 0);
    run_op("undef",   4'd12, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b0, 2, 0);
    run_op("mul_ign", 4'd8, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 5);
`ifdef ALU_MULHI_EN
    run_op("mulhu",   4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33, 0);
`else
    run_op("op9",     4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 2, 0);
`endif
    run_op("mul",     4'd8, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 1'b0, 1'b0, 33, 0);

    // Abort a multiply with an asynchronous reset between clock edges.
    src1 = 32'h0000_FFFF; src2 = 32'h0001_0001; opcode = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("abort.busy_pre", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("abort.busy", W'(busy), W'(0));
    check("abort.done", W'(done), W'(0));
    check("abort.res", result, '0);
    check("abort.flags", W'({zero, overflow}), W'(0));
    check("abort.state", W'(dbg_state), W'(0));
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort.no_done", W'(seen), W'(0));
    last_res = '0;

    run_op("recover", 4'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of the register file; consumes its two read operands (Source1, Source2) and produces one 32-bit result per issued operation.
- Single-cycle logic/arithmetic ops finish in one EXEC cycle.
- Unsigned multiply is iterative shift-add, one bit per cycle.
- start/busy/done handshake lets the issue logic stall while a multiply is in flight.

Parameters:
- WIDTH, 32, operand/result width; must equal register file data width.
- CNT_W, 6, multiply iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request; sampled only in IDLE
- opcode  input  4  operation select, latched with start
- Source1  input  WIDTH  operand A from register file
- Source2  input  WIDTH  operand B from register file
- busy  output  1  high in EXEC, MUL, DONE states
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  operation result, held until next done
- zero  output  1  result == 0, registered with result
- overflow  output  1  signed overflow for ADD/SUB, else 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, zero=0, overflow=0, internal operand/accumulator/counter regs=0. Reset mid-operation aborts silently; no done is produced.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLT (signed A<B → 1 else 0), 6 SLL (A << B[4:0]), 7 SRL (logical, A >> B[4:0]), 8 MUL (low WIDTH bits of unsigned A*B). 9 is MULHU (see Optional Feature). 10-15 undefined: result=0, overflow=0, normal single-cycle completion.
- All arithmetic is modulo 2^WIDTH. overflow for ADD: A,B same sign and sum sign differs. For SUB: A,B differ in sign and diff sign differs from A.
- States: IDLE, EXEC, MUL, DONE.
- IDLE: start=1 at edge N latches Source1, Source2, opcode. Next state is MUL for opcode 8/9 (accumulator=0, counter=0), otherwise EXEC.
- EXEC: at edge N+1 the result/zero/overflow registers update and state goes to DONE.
- MUL: each edge, if multiplier LSB=1 then add multiplicand to the upper half of a 2*WIDTH accumulator, then shift right 1. After WIDTH iterations (edges N+1..N+WIDTH) the result is written on the final edge and state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=1; next edge goes to IDLE.
- Latency start→done-visible: 2 cycles for single-cycle ops, WIDTH+1 for MUL.
- Throughput: a new start is accepted earliest the cycle after done (back-to-back ALU ops = one every 3 cycles).
- start while busy is ignored; it is not queued.
- Source1/Source2/opcode changes after the latch edge have no effect on the in-flight operation.
- result/zero/overflow hold their values from the last completed operation until the next completion.
- Shift amount uses only B[4:0]; a shift by 0 returns A.

Optional Feature:
- Macro ALU_MULHI_EN.
- Defined: opcode 9 MULHU runs the same MUL sequence and returns the high WIDTH bits of the unsigned product; latency WIDTH+1.
- Undefined: opcode 9 is undefined (result 0, single-cycle EXEC path), no extra logic.

Test Plan:
- Reset: assert rst_n=0 mid-MUL at cycle 10 → busy=0, done=0, result=0 immediately (asynchronously); no done after release.
- ADD overflow: A=0x7FFFFFFF, B=0x00000001, op 0 → done 2 cycles after start, result=0x80000000, overflow=1, zero=0.
- SUB zero/SLT: A=B=0x12345678, op 1 → result=0, zero=1. Then A=0xFFFFFFFF, B=0x00000001, op 5 → result=1.
- Shift: A=0x80000001, B=0x00000024, op 7 → shift by 4 → result=0x08000000. Same operands, op 6 → result=0x00000010.
- MUL with ignored start: A=0x0000FFFF, B=0x00010001, op 8 → done exactly 33 cycles after start, result=0xFFFFFFFF. A second start pulsed at cycle 5 with op 0 is ignored.
- ALU_MULHI_EN: A=B=0xFFFFFFFF, op 9 → with macro, result=0xFFFFFFFE after 33 cycles; without macro, result=0 after 2 cycles.
